// File: rtl/multiply_accumulate_2_bit.sv
// Accumulates PRODUCT_COUNT unsigned 4-bit products into one frame sum and
// presents it on a valid/ready handshake. Wraps mod 2**ACC_WIDTH with a sticky overflow flag.
//
// state | meaning
// ACCUM | accepting products, Sum_Out shows the running partial sum
// HOLD  | frame complete, Sum_Out/Overflow_Out held until Sum_Ready_In
module multiply_accumulate_2_bit #(
  parameter int ACC_WIDTH     = 8,
  parameter int PRODUCT_COUNT = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                 Clock_In,
  input  logic                 Reset_In,
  input  logic                 Clear_In,
  input  logic [3:0]           Product_In,
  input  logic                 Product_Valid_In,
  output logic                 Product_Ready_Out,
  output logic [ACC_WIDTH-1:0] Sum_Out,
  output logic                 Sum_Valid_Out,
  input  logic                 Sum_Ready_In,
  output logic                 Overflow_Out
);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(PRODUCT_COUNT - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_ovf;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_release;
  logic [ACC_WIDTH:0]     w_sum;

  // Extra top bit of w_sum is the carry out that feeds the sticky overflow.
  assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH + 1)'(Product_In);
  assign w_accept  = Product_Valid_In & Product_Ready_Out;
  assign w_last    = (r_count == LP_LAST);
  assign w_release = (r_state == S_HOLD) & Sum_Ready_In;

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (Clear_In) begin
      w_state_nxt = S_ACCUM;
    end else begin
      case (r_state)
        S_ACCUM: if (w_accept && w_last) w_state_nxt = S_HOLD;
        S_HOLD:  if (Sum_Ready_In)       w_state_nxt = S_ACCUM;
        default: w_state_nxt = S_ACCUM;
      endcase
    end
  end

  // Handshake outputs depend on state only, so Sum_Ready_In never reaches Product_Ready_Out.
  always_comb begin
    Product_Ready_Out = (r_state == S_ACCUM);
    Sum_Valid_Out     = (r_state == S_HOLD);
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (Clear_In) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_sum[ACC_WIDTH-1:0];
      r_ovf   <= r_ovf | w_sum[ACC_WIDTH];
      r_count <= w_last ? '0 : r_count + CNT_WIDTH'(1);
    end else if (w_release) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end
  end

  assign Sum_Out      = r_acc;
  assign Overflow_Out = r_ovf;

endmodule

// File: tb/tb_multiply_accumulate_2_bit.sv
// Drives three configurations of the accumulator from shared inputs and checks
// each against a frame-level arithmetic model, plus directed scenario checks.
module tb_multiply_accumulate_2_bit;

  logic       clk_sys = 1'b0;
  logic       rst     = 1'b1;
  logic       clr     = 1'b0;
  logic [3:0] prod    = '0;
  logic       pvalid  = 1'b0;
  logic       sready  = 1'b0;

  logic       rdy [3];
  logic       vld [3];
  logic       ovf [3];
  logic [7:0] s0;
  logic [3:0] s1;
  logic [7:0] s2;

  int n_checks = 0;
  int n_errors = 0;

  // model: per instance frame total, products taken, hold flag
  int          cfg_w [3] = '{8, 4, 8};
  int          cfg_n [3] = '{4, 4, 1};
  int unsigned m_total [3];
  int          m_n [3];
  bit          m_hold [3];

  always #5 clk_sys = ~clk_sys;

  multiply_accumulate_2_bit #(.ACC_WIDTH(8), .PRODUCT_COUNT(4), .CNT_WIDTH(3)) u_dut0 (
    .Clock_In(clk_sys), .Reset_In(rst), .Clear_In(clr), .Product_In(prod),
    .Product_Valid_In(pvalid), .Product_Ready_Out(rdy[0]), .Sum_Out(s0),
    .Sum_Valid_Out(vld[0]), .Sum_Ready_In(sready), .Overflow_Out(ovf[0]));

  multiply_accumulate_2_bit #(.ACC_WIDTH(4), .PRODUCT_COUNT(4), .CNT_WIDTH(3)) u_dut1 (
    .Clock_In(clk_sys), .Reset_In(rst), .Clear_In(clr), .Product_In(prod),
    .Product_Valid_In(pvalid), .Product_Ready_Out(rdy[1]), .Sum_Out(s1),
    .Sum_Valid_Out(vld[1]), .Sum_Ready_In(sready), .Overflow_Out(ovf[1]));

  multiply_accumulate_2_bit #(.ACC_WIDTH(8), .PRODUCT_COUNT(1), .CNT_WIDTH(3)) u_dut2 (
    .Clock_In(clk_sys), .Reset_In(rst), .Clear_In(clr), .Product_In(prod),
    .Product_Valid_In(pvalid), .Product_Ready_Out(rdy[2]), .Sum_Out(s2),
    .Sum_Valid_Out(vld[2]), .Sum_Ready_In(sready), .Overflow_Out(ovf[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sum_of(input int k);
    case (k)
      0:       return {24'd0, s0};
      1:       return {28'd0, s1};
      default: return {24'd0, s2};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_total[k] = 0;
      m_n[k]     = 0;
      m_hold[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (rst || clr || (m_hold[k] && sready)) begin
        m_total[k] = 0;
        m_n[k]     = 0;
        m_hold[k]  = 1'b0;
      end else if (!m_hold[k] && pvalid) begin
        m_total[k] += prod;
        m_n[k]++;
        if (m_n[k] == cfg_n[k]) m_hold[k] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int unsigned lim;
    for (int k = 0; k < 3; k++) begin
      lim = (1 << cfg_w[k]) - 1;
      check($sformatf("rdy%0d", k), 32'(rdy[k]), 32'(!m_hold[k]));
      check($sformatf("vld%0d", k), 32'(vld[k]), 32'(m_hold[k]));
      check($sformatf("sum%0d", k), sum_of(k), m_total[k] & lim);
      check($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(m_total[k] > lim));
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [3:0] p, input bit sr, input bit c);
    pvalid = v;
    prod   = p;
    sready = sr;
    clr    = c;
    step();
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_rdy", 32'(rdy[0]), 32'd1);
    check("reset_sum", sum_of(0), 32'd0);
    step();
    step();
    rst = 1'b0;

    // back-to-back 9s: 36 in the 8-bit instance, 36 mod 16 with overflow in the 4-bit one
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd9, 1'b1, 1'b0);
    check("t2_sum", sum_of(0), 32'd36);
    check("t2_vld", 32'(vld[0]), 32'd1);
    check("t2_ovf", 32'(ovf[0]), 32'd0);
    check("t4_sum", sum_of(1), 32'd4);
    check("t4_ovf", 32'(ovf[1]), 32'd1);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    check("t2_vld_drop", 32'(vld[0]), 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd1, 1'b1, 1'b0);
    check("t4_sum2", sum_of(1), 32'd4);
    check("t4_ovf2", 32'(ovf[1]), 32'd0);
    drive(1'b0, 4'd0, 1'b1, 1'b0);

    // bubbles, held frame with an ignored product, then the next frame
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    foreach (cfg_w[i]) begin end
    begin
      logic [3:0] seq [4];
      seq = '{4'd1, 4'd0, 4'd2, 4'd3};
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, seq[i], 1'b0, 1'b0);
        if (i < 3) begin
          drive(1'b0, 4'd0, 1'b0, 1'b0);
          drive(1'b0, 4'd0, 1'b0, 1'b0);
        end
      end
    end
    check("t3_sum", sum_of(0), 32'd6);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd9, 1'b0, 1'b0);
      check("t3_hold_sum", sum_of(0), 32'd6);
      check("t3_hold_rdy", 32'(rdy[0]), 32'd0);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    check("t3_release_vld", 32'(vld[0]), 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd4, 1'b0, 1'b0);
    check("t3_sum2", sum_of(0), 32'd16);
    drive(1'b0, 4'd0, 1'b1, 1'b0);

    // clear drops a product presented with it
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    drive(1'b1, 4'd9, 1'b0, 1'b1);
    check("t5_clr_sum", sum_of(0), 32'd0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
    check("t5_sum", sum_of(0), 32'd10);
    drive(1'b0, 4'd0, 1'b1, 1'b0);

    // single-product frames
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 4'd5, 1'b1, 1'b0);
    check("t6_sum5", sum_of(2), 32'd5);
    check("t6_rdy0", 32'(rdy[2]), 32'd0);
    drive(1'b1, 4'd6, 1'b1, 1'b0);
    check("t6_rdy1", 32'(rdy[2]), 32'd1);
    drive(1'b1, 4'd6, 1'b1, 1'b0);
    check("t6_sum6", sum_of(2), 32'd6);
    check("t6_rdy0b", 32'(rdy[2]), 32'd0);

    // async reset while holding an overflowed frame
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd9, 1'b0, 1'b0);
    check("t1_pre_vld", 32'(vld[0]), 32'd1);
    check("t1_pre_ovf", 32'(ovf[1]), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("t1_vld", 32'(vld[0]), 32'd0);
    check("t1_sum", sum_of(0), 32'd0);
    check("t1_ovf", 32'(ovf[1]), 32'd0);
    check("t1_rdy", 32'(rdy[0]), 32'd1);
    step();
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
